// File: rtl/nand_sched_pkg.sv
// Shared definitions for the four-way NAND scheduler tile.
package nand_sched_pkg;

    localparam int NUM_REQ  = 4;

    // Pin positions inside ui_in
    localparam int REQ_LSB  = 0;
    localparam int CLR_BIT  = 4;
    localparam int HOLD_BIT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        ACK  = 2'd2,
        WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter: picks the first set request at or after last+1 (mod 4).
module rr_arbiter4
    import nand_sched_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] g
);

    // rot[k] is the request that sits k+1 positions after the last winner
    logic [3:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = req[last + 2'(gi + 1)];
        end
    endgenerate

    assign any = |req;

    // Lowest rotated offset wins; map the offset back to an absolute index
    always_comb begin
        logic [1:0] off;
        off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) begin
                off = 2'(k);
            end
        end
        g = last + off + 2'd1;
    end

endmodule

// File: rtl/tt_um_christina_mankowski_nand_sched.sv
// Tiny Tapeout tile: four requesters share one NAND unit under round-robin
// scheduling with a grant/request handshake and per-requester result latches.
module tt_um_christina_mankowski_nand_sched
    import nand_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [NUM_REQ-1:0] req;
    logic               clr;
    logic               hold;
    logic [NUM_REQ-1:0] opnd_a;
    logic [NUM_REQ-1:0] opnd_b;

    assign req  = ui_in[REQ_LSB +: NUM_REQ];
    assign clr  = ui_in[CLR_BIT];
    assign hold = ui_in[HOLD_BIT];

    // Operand pairs are interleaved on uio_in: A at even pins, B at odd pins
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_opnd
            assign opnd_a[gi] = uio_in[2*gi];
            assign opnd_b[gi] = uio_in[2*gi+1];
        end
    endgenerate

    state_t             state_reg;
    logic [1:0]         sel_reg;
    logic [1:0]         last_reg;
    logic               op_a_reg;
    logic               op_b_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [NUM_REQ-1:0] result_reg;

    logic               arb_any;
    logic [1:0]         arb_g;

    rr_arbiter4 u_arb (
        .req  (req),
        .last (last_reg),
        .any  (arb_any),
        .g    (arb_g)
    );

    // Scheduler FSM with operand capture, NAND evaluation and registered grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sel_reg    <= 2'd0;
            last_reg   <= 2'd3;
            op_a_reg   <= 1'b0;
            op_b_reg   <= 1'b0;
            grant_reg  <= '0;
            result_reg <= '0;
        end else begin
            // clr wipes every result; an EVAL write below overrides its own bit
            if (clr) begin
                result_reg <= '0;
            end
            case (state_reg)
                IDLE: begin
                    grant_reg <= '0;
                    if (!hold && arb_any) begin
                        sel_reg   <= arb_g;
                        op_a_reg  <= opnd_a[arb_g];
                        op_b_reg  <= opnd_b[arb_g];
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    result_reg[sel_reg] <= ~(op_a_reg & op_b_reg);
                    last_reg            <= sel_reg;
                    grant_reg           <= NUM_REQ'(1) << sel_reg;
                    state_reg           <= ACK;
                end
                ACK: begin
                    grant_reg <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    grant_reg <= '0;
                    if (!req[sel_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign uo_out  = {result_reg, grant_reg};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic _unused;
    assign _unused = &{1'b0, ena, ui_in[7:6]};

endmodule

// File: tb/tb_tt_um_christina_mankowski_nand_sched.sv
// Directed self-checking bench for the NAND scheduler tile.
module tb_tt_um_christina_mankowski_nand_sched;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    tt_um_christina_mankowski_nand_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end else begin
            $display("ok   %s observed=%02h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] g;
        ena    = 1'b1;
        rst_n  = 1'b0;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);

        // Reset with random inputs
        tick(); tick(); tick();
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b1;
        tick(); tick(); tick();
        check("idle_no_req", uo_out, 8'h00);

        // Single transaction, requester 0, A=B=1; operands flipped during EVAL
        uio_in = 8'h03;
        ui_in  = 8'h01;
        tick();
        check("t0_eval_nogrant", uo_out, 8'h00);
        uio_in = 8'h00;
        tick();
        check("t0_ack", uo_out, 8'h01);
        ui_in = 8'h00;
        tick();
        check("t0_wait", uo_out, 8'h00);
        tick();

        // Requester 0 again, A=0 B=1 -> result 1
        uio_in = 8'h02;
        ui_in  = 8'h01;
        tick();
        check("t1_eval_nogrant", uo_out, 8'h00);
        tick();
        check("t1_ack", uo_out, 8'h11);
        ui_in = 8'h00;
        tick();
        tick();

        // Fairness: all requesting, last=0 -> order 1,2,3,0,1,2,3,0
        uio_in = 8'h00;
        ui_in  = 8'h0F;
        for (int k = 0; k < 8; k++) begin
            g = 2'((k + 1) % 4);
            tick();
            tick();
            check($sformatf("rr_grant_%0d", k), {4'h0, uo_out[3:0]}, 8'(1) << g);
            ui_in[g] = 1'b0;
            tick();
            tick();
            ui_in[g] = 1'b1;
        end
        ui_in = 8'h00;
        tick();
        check("rr_results", uo_out, 8'hF0);

        // Handshake: requester 2 holds req, requester 1 pending
        uio_in = 8'h30;
        ui_in  = 8'h04;
        tick();
        uio_in = 8'h00;
        tick();
        check("hs_ack2", uo_out, 8'hB4);
        ui_in = 8'h06;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("hs_wait_%0d", k), {4'h0, uo_out[3:0]}, 8'h00);
        end
        ui_in = 8'h02;
        tick();
        check("hs_after_drop", {4'h0, uo_out[3:0]}, 8'h00);
        tick();
        check("hs_eval1", {4'h0, uo_out[3:0]}, 8'h00);
        tick();
        check("hs_ack1", uo_out, 8'hB2);
        ui_in = 8'h00;
        tick();
        tick();

        // Hold blocks new grants
        uio_in = 8'hC0;
        ui_in  = 8'h28;
        for (int k = 0; k < 20; k++) begin
            tick();
            check($sformatf("hold_%0d", k), {4'h0, uo_out[3:0]}, 8'h00);
        end
        ui_in = 8'h08;
        tick();
        check("hold_rel_eval", {4'h0, uo_out[3:0]}, 8'h00);
        tick();
        check("hold_rel_ack3", uo_out, 8'h38);
        ui_in = 8'h00;
        tick();
        tick();

        // clr on the EVAL edge of requester 1: only new result1 survives
        uio_in = 8'h00;
        ui_in  = 8'h02;
        tick();
        ui_in = 8'h12;
        tick();
        check("clr_eval_ack1", uo_out, 8'h22);
        ui_in = 8'h00;
        tick();
        check("clr_wait", uo_out, 8'h20);
        tick();
        ui_in = 8'h10;
        tick();
        check("clr_idle", uo_out, 8'h00);
        ui_in = 8'h00;

        // Serve requester 2 so last=2 and a result bit is set
        ui_in = 8'h04;
        tick();
        tick();
        check("pre_rst_ack2", uo_out, 8'h44);
        ui_in = 8'h00;
        tick();
        tick();

        // Reset during EVAL of requester 3
        ui_in = 8'h08;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", uo_out, 8'h00);
        #1;
        rst_n  = 1'b1;
        ui_in  = 8'h0F;
        uio_in = 8'hFF;
        tick();
        check("rst_mid_eval", uo_out, 8'h00);
        tick();
        check("rst_mid_first0", uo_out, 8'h01);
        ui_in = 8'h00;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
